counter_req_arbiter: RTL
========================

# counter_req_arbiter

Shares one up/down counter register among `N_REQ` requesters, such as the button auto-repeat front ends, a UART command decoder or a test sequencer. Each requester posts a direction and step size. A round-robin arbiter grants one request per transaction and applies it to the counter with range limiting. Every serviced request is acknowledged, and a hold-off window spaces consecutive updates.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH_COUNTER`, 8, counter width
- `WIDTH_STEP`, 8, step operand width (≤ `WIDTH_COUNTER`)
- `MIN_VAL`, 0, lower bound (saturating build only)
- `MAX_VAL`, 255, upper bound (saturating build only); `MIN_VAL` ≤ `RESET_VAL` ≤ `MAX_VAL`
- `RESET_VAL`, 0, counter value after reset/clear
- `HOLDOFF`, 4, cycles spent in HOLD after each update (≥ 1)

Ports:
- `clk_i`  in  1  clock
- `reset_ni`  in  1  reset, asynchronous, active-low
- `req_i`  in  `N_REQ`  request per requester, level
- `dir_i`  in  `N_REQ`  direction per requester; 1 = up, 0 = down
- `step_i`  in  `N_REQ`×`WIDTH_STEP`  step per requester
- `clear_i`  in  1  synchronous clear, highest priority
- `ack_o`  out  `N_REQ`  one-cycle acknowledge, one-hot
- `grant_id_o`  out  `$clog2(N_REQ)`  index of latched winner
- `busy_o`  out  1  high when FSM not in IDLE
- `sat_o`  out  1  one-cycle pulse when an update was clamped
- `counter_o`  out  `WIDTH_COUNTER`  shared counter value

## Operation
- **FSM states:** IDLE, UPDATE, HOLD.
- **IDLE:** if any `req_i` is set, pick a winner and go to UPDATE.
  - The search starts at `last_grant`+1 and wraps modulo `N_REQ`.
  - Latch the winner index, `dir_i[w]` and `step_i[w]`, and set `last_grant` = w.
- **UPDATE:** write the new `counter_o`, set `ack_o[w]`=1 and `sat_o` if clamped, load the hold counter with `HOLDOFF`, and go to HOLD.
- **HOLD:** decrement the hold counter and return to IDLE when it reaches 1. No arbitration occurs in HOLD.
- **Handshake:**
  - A requester holds `req_i`, `dir_i` and `step_i` stable until its `ack_o` pulse.
  - Operands are latched at grant, so deasserting `req_i` after the grant does not cancel the update.
  - Deasserting before the grant withdraws the request silently.
- **Arithmetic:** computed at `WIDTH_COUNTER`+1 bits with the step zero-extended.
  - A step of 0 still completes a full transaction with ack and no value change.
- **`clear_i`:** in any state, sets `counter_o`=`RESET_VAL` and FSM=IDLE, drops any latched grant without ack, and holds `sat_o`=0. `last_grant` is unchanged. If `clear_i` and a grant coincide, clear wins.
- **Reset values:**
  - `counter_o`=`RESET_VAL`, `ack_o`=0, `sat_o`=0, `busy_o`=0, `grant_id_o`=0.
  - FSM=IDLE, `last_grant`=`N_REQ`−1, so requester 0 has first priority.
- **Reset mid-transaction:** all state returns to reset values immediately (asynchronous). No ack is issued.

## Timing
- `req_i` is sampled high in IDLE at edge t; the FSM is in UPDATE during cycle t+1.
- `counter_o` shows the new value and `ack_o`/`sat_o` are high in cycle t+2.
- `ack_o` and `sat_o` are registered and high for exactly one cycle.
- Minimum spacing between two updates is 2 + `HOLDOFF` cycles.
- `busy_o` goes high the cycle after the grant edge and low on return to IDLE.
- A requester that keeps `req_i` high after its ack is re-arbitrated fairly in the next IDLE, after any other pending requesters.

## Configuration
- Macro: `COUNTER_ARB_SATURATE_EN`.
- **Defined:**
  - Up: result = min(counter+step, `MAX_VAL`).
  - Down: result = max(counter−step, `MIN_VAL`), with no underflow.
  - `sat_o` pulses when the clamp changes the result.
- **Undefined:** result wraps modulo 2^`WIDTH_COUNTER`. `MIN_VAL`/`MAX_VAL` are ignored and `sat_o` is tied 0.

## Test plan
- **Single request:** reset, then `req_i[1]`=1, `dir`=up, `step`=10 → `ack_o`=0b0010 and `counter_o`=10 exactly 2 cycles after sampling; `busy_o` high for 1 + `HOLDOFF` cycles.
- **Round robin:** `req_i`=0b0101 held, step 1, up → acks in order 0, 2, 0, 2; `counter_o` increments by 1 every 2 + `HOLDOFF` cycles; `grant_id_o` alternates 0/2.
- **Saturation (macro defined):** `counter_o`=250, up step 10 → `counter_o`=255, `sat_o` pulses 1 cycle. Then `counter_o`=3, down step 5 → 0, `sat_o` pulses.
- **Wrap (macro undefined):** `counter_o`=250, up step 10 → `counter_o`=4, `sat_o`=0. Then `counter_o`=3, down step 5 → 254.
- **Clear in UPDATE:** assert `clear_i` during the UPDATE cycle of a granted up step 10 → `counter_o`=`RESET_VAL`, no `ack_o`, FSM IDLE. The held request is then granted and acked, giving `RESET_VAL`+10.
- **Async reset in HOLD:** assert `reset_ni`=0 during HOLD → all outputs at reset values immediately. After release, the first grant goes to requester 0 when `req_i`=0b1111.

Source files
------------

// File: rtl/counter_req_arbiter.sv
// ---------------------------------------------------------------------------
// counter_req_arbiter
//
// Shares one up/down counter among N_REQ requesters. A round-robin arbiter
// grants one request per transaction. The winner's direction and step are
// latched and applied to the counter, the winner gets a one-cycle ack, and a
// hold-off window of HOLDOFF cycles follows every update.
//
// Build option:
//   COUNTER_ARB_SATURATE_EN - when defined, results are clamped to
//   [MIN_VAL, MAX_VAL] and sat_o pulses whenever the clamp changes the
//   result. When undefined, the counter wraps modulo 2^WIDTH_COUNTER and
//   sat_o stays 0.
//
// Ports:
//   clk_i       clock
//   reset_ni    asynchronous active-low reset
//   req_i       level request per requester
//   dir_i       direction per requester (1 = up, 0 = down)
//   step_i      step per requester, requester k at [k*WIDTH_STEP +: WIDTH_STEP]
//   clear_i     synchronous clear, overrides everything else
//   ack_o       one-cycle one-hot acknowledge of the serviced requester
//   grant_id_o  index of the latched winner
//   busy_o      high while the FSM is not in IDLE
//   sat_o       one-cycle pulse when an update was clamped
//   counter_o   shared counter value
// ---------------------------------------------------------------------------
module counter_req_arbiter #(
  parameter int N_REQ         = 4,
  parameter int WIDTH_COUNTER = 8,
  parameter int WIDTH_STEP    = 8,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int RESET_VAL     = 0,
  parameter int HOLDOFF       = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              dir_i,
  input  logic [N_REQ*WIDTH_STEP-1:0]   step_i,
  input  logic                          clear_i,
  output logic [N_REQ-1:0]              ack_o,
  output logic [$clog2(N_REQ)-1:0]      grant_id_o,
  output logic                          busy_o,
  output logic                          sat_o,
  output logic [WIDTH_COUNTER-1:0]      counter_o
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int HW   = $clog2(HOLDOFF + 1);

  // Reset value pinned inside [MIN_VAL, MAX_VAL] so a mis-set RESET_VAL can
  // never start the counter outside its legal range.
  localparam int RESET_SAFE = (RESET_VAL < MIN_VAL) ? MIN_VAL :
                              ((RESET_VAL > MAX_VAL) ? MAX_VAL : RESET_VAL);
  localparam logic [WIDTH_COUNTER-1:0] RESET_CNT = WIDTH_COUNTER'(RESET_SAFE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IDXW-1:0]          last_grant_q, last_grant_d;
  logic [IDXW-1:0]          grant_id_q, grant_id_d;
  logic                     dir_q, dir_d;
  logic [WIDTH_STEP-1:0]    step_q, step_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic [WIDTH_COUNTER-1:0] counter_q, counter_d;
  logic [N_REQ-1:0]         ack_q, ack_d;
  logic                     sat_q, sat_d;

  logic                     found_s;
  logic [IDXW-1:0]          winner_s;
  logic [IDXW-1:0]          cand_s;
  logic [WIDTH_COUNTER-1:0] result_s;
  logic                     clamp_s;

  // Round-robin search: first requester after last_grant, wrapping.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_grant_q;
    cand_s   = last_grant_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s   = IDXW'((int'(last_grant_q) + i) % N_REQ);
      winner_s = (!found_s && req_i[cand_s]) ? cand_s : winner_s;
      found_s  = found_s | req_i[cand_s];
    end
  end

`ifdef COUNTER_ARB_SATURATE_EN
  localparam logic [WIDTH_COUNTER:0] MIN_EXT = (WIDTH_COUNTER+1)'(MIN_VAL);
  localparam logic [WIDTH_COUNTER:0] MAX_EXT = (WIDTH_COUNTER+1)'(MAX_VAL);

  logic [WIDTH_COUNTER:0] cnt_ext_s;
  logic [WIDTH_COUNTER:0] step_ext_s;
  logic [WIDTH_COUNTER:0] sum_s;
  logic [WIDTH_COUNTER:0] diff_s;

  // Saturating update; one extra bit exposes carry (up) and borrow (down).
  always_comb begin
    cnt_ext_s  = {1'b0, counter_q};
    step_ext_s = (WIDTH_COUNTER+1)'(step_q);
    sum_s      = cnt_ext_s + step_ext_s;
    diff_s     = cnt_ext_s - step_ext_s;
    if (dir_q) begin
      if (sum_s > MAX_EXT) begin
        result_s = MAX_EXT[WIDTH_COUNTER-1:0];
        clamp_s  = 1'b1;
      end else begin
        result_s = sum_s[WIDTH_COUNTER-1:0];
        clamp_s  = 1'b0;
      end
    end else begin
      // diff_s MSB set means the subtraction borrowed, i.e. went below zero.
      if (diff_s[WIDTH_COUNTER] || (diff_s < MIN_EXT)) begin
        result_s = MIN_EXT[WIDTH_COUNTER-1:0];
        clamp_s  = 1'b1;
      end else begin
        result_s = diff_s[WIDTH_COUNTER-1:0];
        clamp_s  = 1'b0;
      end
    end
  end
`else
  // Wrapping update modulo 2^WIDTH_COUNTER; never reports a clamp.
  always_comb begin
    if (dir_q) begin
      result_s = counter_q + WIDTH_COUNTER'(step_q);
    end else begin
      result_s = counter_q - WIDTH_COUNTER'(step_q);
    end
    clamp_s = 1'b0;
  end
`endif

  // Next-state and registered-output logic of the IDLE/UPDATE/HOLD FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    dir_d        = dir_q;
    step_d       = step_q;
    hold_d       = hold_q;
    counter_d    = counter_q;
    ack_d        = '0;
    sat_d        = 1'b0;
    if (clear_i) begin
      // Clear beats a coinciding grant; last_grant is deliberately kept.
      state_d   = ST_IDLE;
      counter_d = RESET_CNT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_s) begin
            state_d      = ST_UPDATE;
            last_grant_d = winner_s;
            grant_id_d   = winner_s;
            dir_d        = dir_i[winner_s];
            step_d       = step_i[int'(winner_s)*WIDTH_STEP +: WIDTH_STEP];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_UPDATE: begin
          counter_d         = result_s;
          sat_d             = clamp_s;
          ack_d[grant_id_q] = 1'b1;
          hold_d            = HW'(HOLDOFF);
          state_d           = ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_q <= HW'(1)) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDXW'(N_REQ - 1);
      grant_id_q   <= '0;
      dir_q        <= 1'b0;
      step_q       <= '0;
      hold_q       <= '0;
      counter_q    <= RESET_CNT;
      ack_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      dir_q        <= dir_d;
      step_q       <= step_d;
      hold_q       <= hold_d;
      counter_q    <= counter_d;
      ack_q        <= ack_d;
      sat_q        <= sat_d;
    end
  end

  assign ack_o      = ack_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign sat_o      = sat_q;
  assign counter_o  = counter_q;

endmodule
